// File: rtl/iic_cfg_pkg.sv
// Shared types for the I2C configuration sequencer.
//   cfg_state_e : sequencer FSM states (table path, then manual path)
//   cfg_entry_t : one initialisation table entry {dev, reg_addr, data}
//   END_MARK    : device address that terminates the table
// Optional feature macro used by the sequencer: IIC_CFG_READBACK_EN.
package iic_cfg_pkg;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_LOAD  = 4'd1,
        ST_REQ   = 4'd2,
        ST_WAIT  = 4'd3,
        ST_CHECK = 4'd4,
        ST_NEXT  = 4'd5,
        ST_DONE  = 4'd6,
        ST_MLOAD = 4'd7,
        ST_MREQ  = 4'd8,
        ST_MWAIT = 4'd9,
        ST_MCHK  = 4'd10
    } cfg_state_e;

    // "reg" is a keyword, so the register address field is reg_addr.
    typedef struct packed {
        logic [7:0]  dev;
        logic [15:0] reg_addr;
        logic [7:0]  data;
    } cfg_entry_t;

    localparam logic [7:0] END_MARK = 8'hFF;

endpackage

// File: rtl/iic_cfg_rom.sv
// Register-initialisation table. Purely combinational: index -> entry.
// Any index beyond the populated entries returns END_MARK, which stops the run.
// Ports:
//   idx   : table index
//   entry : {dev, reg_addr, data} for that index
module iic_cfg_rom
    import iic_cfg_pkg::*;
#(
    parameter int TABLE_DEPTH = 16
) (
    input  logic [$clog2(TABLE_DEPTH)-1:0] idx,
    output cfg_entry_t                     entry
);

    always_comb begin
        entry = '{dev: END_MARK, reg_addr: 16'h0000, data: 8'h00};
        case (int'(idx))
            0:       entry = '{dev: 8'h50, reg_addr: 16'h0010, data: 8'h3C};
            1:       entry = '{dev: 8'h50, reg_addr: 16'h0020, data: 8'h5A};
            2:       entry = '{dev: 8'h52, reg_addr: 16'h0100, data: 8'hC3};
            default: entry = '{dev: END_MARK, reg_addr: 16'h0000, data: 8'h00};
        endcase
    end

endmodule

// File: rtl/iic_cfg_sequencer.sv
// Sequencer/arbiter in front of iic_drive. After cfg_start it walks the
// initialisation table (iic_cfg_rom), one I2C write per entry with retry on
// error or timeout. When idle it serves single manual transactions.
//
// Optional feature: define IIC_CFG_READBACK_EN to follow every successful
// table write with a read of the same dev/reg; a data mismatch counts as an
// error and goes through the normal retry rules.
//
// Handshake to iic_drive: drv_start is a level held from REQ entry until the
// registered drv_busy is seen high; the transfer is complete when registered
// drv_busy returns low. drv_dev/reg/data/wr_rd are stable throughout.
// Manual side: man_req is a level held by the requester until the one-cycle
// man_ack; man_err/man_rd_data are valid in the ack cycle and held afterwards.
//
// Ports:
//   clk_8m, rst_n           : clock, asynchronous active-low reset
//   cfg_start               : pulse, starts a table run (ignored unless idle)
//   man_req/wr_rd/dev/reg/data : manual request and its fields
//   man_ack/man_rd_data/man_err : manual completion pulse and result
//   drv_start/wr_rd/dev/reg/data : request to iic_drive
//   drv_busy/err/rd_data    : status from iic_drive
//   cfg_busy/done/fail      : table run status (done/fail sticky)
//   fail_index              : table index of the entry that failed
//   state_dbg               : current FSM state
module iic_cfg_sequencer
    import iic_cfg_pkg::*;
#(
    parameter int TABLE_DEPTH = 16,
    parameter int MAX_RETRY   = 3,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic                           clk_8m,
    input  logic                           rst_n,
    input  logic                           cfg_start,
    input  logic                           man_req,
    input  logic                           man_wr_rd,
    input  logic [7:0]                     man_dev,
    input  logic [15:0]                    man_reg,
    input  logic [7:0]                     man_data,
    output logic                           man_ack,
    output logic [7:0]                     man_rd_data,
    output logic                           man_err,
    output logic                           drv_start,
    output logic                           drv_wr_rd,
    output logic [7:0]                     drv_dev,
    output logic [15:0]                    drv_reg,
    output logic [7:0]                     drv_data,
    input  logic                           drv_busy,
    input  logic                           drv_err,
    input  logic [7:0]                     drv_rd_data,
    output logic                           cfg_busy,
    output logic                           cfg_done,
    output logic                           cfg_fail,
    output logic [$clog2(TABLE_DEPTH)-1:0] fail_index,
    output cfg_state_e                     state_dbg
);

    localparam int IDX_W = $clog2(TABLE_DEPTH);
    // One extra bit so the index can reach TABLE_DEPTH and end the run.
    localparam int CNT_W = $clog2(TABLE_DEPTH + 1);
    localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    cfg_state_e       state_q, state_d;
    logic             busy_q, err_q;
    logic [CNT_W-1:0] idx_q;
    logic [RTY_W-1:0] retry_q;
    logic [TMO_W-1:0] tmo_cnt_q;
    logic             tmo_flag_q;
    logic             in_xfer, tmo_hit, retry_left, chk_err;
    cfg_entry_t       rom_entry;
`ifdef IIC_CFG_READBACK_EN
    logic             rb_phase_q;   // 1 while the readback of the current entry is in flight
`endif

    iic_cfg_rom #(
        .TABLE_DEPTH(TABLE_DEPTH)
    ) u_rom (
        .idx   (idx_q[IDX_W-1:0]),
        .entry (rom_entry)
    );

    assign in_xfer    = (state_q == ST_REQ)  || (state_q == ST_WAIT) ||
                        (state_q == ST_MREQ) || (state_q == ST_MWAIT);
    assign tmo_hit    = in_xfer && (tmo_cnt_q == TMO_W'(TIMEOUT_CYC));
    assign retry_left = (retry_q < RTY_W'(MAX_RETRY));

    // tmo_flag_q remembers that REQ/WAIT was left because of the timeout.
`ifdef IIC_CFG_READBACK_EN
    assign chk_err = err_q | tmo_flag_q | (rb_phase_q & (drv_rd_data != drv_data));
`else
    assign chk_err = err_q | tmo_flag_q;
`endif

    // Pure state decodes: all drop together with the asynchronous reset.
    assign drv_start = (state_q == ST_REQ) || (state_q == ST_MREQ);
    assign man_ack   = (state_q == ST_MCHK);
    assign cfg_busy  = (state_q == ST_LOAD)  || (state_q == ST_REQ)  ||
                       (state_q == ST_WAIT)  || (state_q == ST_CHECK) ||
                       (state_q == ST_NEXT)  || (state_q == ST_DONE);
    assign state_dbg = state_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                // A table run wins; a pending man_req is served afterwards.
                if (cfg_start)    state_d = ST_LOAD;
                else if (man_req) state_d = ST_MLOAD;
            end
            ST_LOAD: begin
                if (rom_entry.dev == END_MARK || idx_q == CNT_W'(TABLE_DEPTH))
                    state_d = ST_DONE;
                else
                    state_d = ST_REQ;
            end
            ST_REQ: begin
                if (busy_q)       state_d = ST_WAIT;
                else if (tmo_hit) state_d = ST_CHECK;
            end
            ST_WAIT: begin
                if (!busy_q || tmo_hit) state_d = ST_CHECK;
            end
            ST_CHECK: begin
                if (chk_err) begin
                    state_d = retry_left ? ST_REQ : ST_IDLE;
                end else begin
`ifdef IIC_CFG_READBACK_EN
                    state_d = rb_phase_q ? ST_NEXT : ST_REQ;
`else
                    state_d = ST_NEXT;
`endif
                end
            end
            ST_NEXT:  state_d = ST_LOAD;
            ST_DONE:  state_d = ST_IDLE;
            ST_MLOAD: state_d = ST_MREQ;
            ST_MREQ: begin
                if (busy_q)       state_d = ST_MWAIT;
                else if (tmo_hit) state_d = ST_MCHK;
            end
            ST_MWAIT: begin
                if (!busy_q || tmo_hit) state_d = ST_MCHK;
            end
            ST_MCHK:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_8m or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
            idx_q       <= '0;
            retry_q     <= '0;
            tmo_cnt_q   <= '0;
            tmo_flag_q  <= 1'b0;
            drv_wr_rd   <= 1'b0;
            drv_dev     <= '0;
            drv_reg     <= '0;
            drv_data    <= '0;
            cfg_done    <= 1'b0;
            cfg_fail    <= 1'b0;
            fail_index  <= '0;
            man_err     <= 1'b0;
            man_rd_data <= '0;
`ifdef IIC_CFG_READBACK_EN
            rb_phase_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            busy_q     <= drv_busy;
            err_q      <= drv_err;
            tmo_flag_q <= tmo_hit;

            // Restarts on every state change, so it is fresh on entry to REQ and WAIT.
            if (state_d != state_q)
                tmo_cnt_q <= '0;
            else if (in_xfer)
                tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);

            case (state_q)
                ST_IDLE: begin
                    if (cfg_start) begin
                        cfg_done   <= 1'b0;
                        cfg_fail   <= 1'b0;
                        idx_q      <= '0;
                        retry_q    <= '0;
`ifdef IIC_CFG_READBACK_EN
                        rb_phase_q <= 1'b0;
`endif
                    end
                end
                ST_LOAD: begin
                    if (state_d == ST_REQ) begin
                        drv_wr_rd <= 1'b0;
                        drv_dev   <= rom_entry.dev;
                        drv_reg   <= rom_entry.reg_addr;
                        drv_data  <= rom_entry.data;
                    end
                end
                ST_CHECK: begin
                    if (chk_err) begin
                        if (retry_left) begin
                            // A retry always restarts the entry with its write.
                            retry_q    <= retry_q + RTY_W'(1);
                            drv_wr_rd  <= 1'b0;
`ifdef IIC_CFG_READBACK_EN
                            rb_phase_q <= 1'b0;
`endif
                        end else begin
                            cfg_fail   <= 1'b1;
                            fail_index <= idx_q[IDX_W-1:0];
                        end
                    end
`ifdef IIC_CFG_READBACK_EN
                    else if (!rb_phase_q) begin
                        rb_phase_q <= 1'b1;
                        drv_wr_rd  <= 1'b1;
                    end
`endif
                end
                ST_NEXT: begin
                    idx_q      <= idx_q + CNT_W'(1);
                    retry_q    <= '0;
`ifdef IIC_CFG_READBACK_EN
                    rb_phase_q <= 1'b0;
`endif
                end
                ST_DONE: cfg_done <= 1'b1;
                ST_MLOAD: begin
                    drv_wr_rd <= man_wr_rd;
                    drv_dev   <= man_dev;
                    drv_reg   <= man_reg;
                    drv_data  <= man_data;
                end
                ST_MREQ, ST_MWAIT: begin
                    // Result is latched on the way into MCHK so it is valid with man_ack.
                    if (state_d == ST_MCHK) begin
                        man_err     <= err_q | tmo_hit;
                        man_rd_data <= drv_rd_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_iic_cfg_sequencer.sv
`timescale 1ns/1ps
module tb_iic_cfg_sequencer;
  import iic_cfg_pkg::*;

  localparam int TMO = 200;
  localparam int MAX_RETRY = 3;

  // ---------------- clock / reset ----------------
  logic clk_8m = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk_8m = ~clk_8m;

  logic        cfg_start = 1'b0;
  logic        man_req = 1'b0;
  logic        man_wr_rd = 1'b0;
  logic [7:0]  man_dev = 8'h00;
  logic [15:0] man_reg = 16'h0000;
  logic [7:0]  man_data = 8'h00;
  logic        man_ack;
  logic [7:0]  man_rd_data;
  logic        man_err;
  logic        drv_start;
  logic        drv_wr_rd;
  logic [7:0]  drv_dev;
  logic [15:0] drv_reg;
  logic [7:0]  drv_data;
  logic        drv_busy;
  logic        drv_err;
  logic [7:0]  drv_rd_data;
  logic        cfg_busy;
  logic        cfg_done;
  logic        cfg_fail;
  logic [3:0]  fail_index;
  cfg_state_e  state_dbg;

  iic_cfg_sequencer #(
    .TABLE_DEPTH(16),
    .MAX_RETRY(MAX_RETRY),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clk_8m(clk_8m), .rst_n(rst_n), .cfg_start(cfg_start),
    .man_req(man_req), .man_wr_rd(man_wr_rd), .man_dev(man_dev),
    .man_reg(man_reg), .man_data(man_data), .man_ack(man_ack),
    .man_rd_data(man_rd_data), .man_err(man_err),
    .drv_start(drv_start), .drv_wr_rd(drv_wr_rd), .drv_dev(drv_dev),
    .drv_reg(drv_reg), .drv_data(drv_data), .drv_busy(drv_busy),
    .drv_err(drv_err), .drv_rd_data(drv_rd_data),
    .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cfg_fail(cfg_fail),
    .fail_index(fail_index), .state_dbg(state_dbg)
  );

  int checks = 0;
  int failures = 0;

  // Expected table contents
  logic [7:0]  tbl_dev [3] = '{8'h50, 8'h50, 8'h52};
  logic [15:0] tbl_reg [3] = '{16'h0010, 16'h0020, 16'h0100};
  logic [7:0]  tbl_data[3] = '{8'h3C, 8'h5A, 8'hC3};

  // Scoreboard: {wr_rd, dev, reg, data} of each expected drv_start handshake
  logic [32:0] exp_q[$];

  // ---------------- iic_drive model ----------------
  bit          resp_never = 1'b0;
  bit          err_en = 1'b0;
  logic [15:0] err_reg = 16'h0000;
  bit          rd_echo = 1'b1;
  logic [7:0]  model_rd_data = 8'hA5;
  logic [15:0] last_wr_reg = 16'hFFFF;
  logic [7:0]  last_wr_data = 8'h00;

  initial begin
    logic       cur_err;
    logic [7:0] cur_rd;
    drv_busy = 1'b0;
    drv_err = 1'b0;
    drv_rd_data = 8'h00;
    forever begin
      @(negedge clk_8m);
      if (rst_n && drv_start && !resp_never) begin
        cur_err = err_en && !drv_wr_rd && (drv_reg == err_reg);
        if (drv_wr_rd) begin
          cur_rd = (rd_echo && drv_reg == last_wr_reg) ? last_wr_data : model_rd_data;
        end else begin
          cur_rd = 8'h00;
          last_wr_reg = drv_reg;
          last_wr_data = drv_data;
        end
        for (int k = 0; k < 3 && rst_n; k++) @(negedge clk_8m);
        if (rst_n) begin
          drv_busy = 1'b1;
          drv_err = 1'b0;
        end
        for (int k = 0; k < 8 && rst_n; k++) @(negedge clk_8m);
        drv_busy = 1'b0;
        if (rst_n) begin
          drv_err = cur_err;
          drv_rd_data = cur_rd;
        end
      end
    end
  end

  // ---------------- monitor: pop and compare on each drv_start rise ----------------
  initial begin
    logic        start_prev;
    logic [32:0] got, want;
    start_prev = 1'b0;
    forever begin
      @(negedge clk_8m);
      if (drv_start && !start_prev) begin
        got = {drv_wr_rd, drv_dev, drv_reg, drv_data};
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL txn_unexpected got=%h required=none t=%0t", got, $time);
        end else begin
          want = exp_q.pop_front();
          if (got !== want) begin
            failures++;
            $display("FAIL txn got=%h required=%h t=%0t", got, want, $time);
          end
        end
      end
      start_prev = drv_start;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_wr(input int i);
    exp_q.push_back({1'b0, tbl_dev[i], tbl_reg[i], tbl_data[i]});
  endtask

  task automatic push_rd(input int i);
    exp_q.push_back({1'b1, tbl_dev[i], tbl_reg[i], tbl_data[i]});
  endtask

  task automatic push_ok(input int i);
    push_wr(i);
`ifdef IIC_CFG_READBACK_EN
    push_rd(i);
`endif
  endtask

  task automatic pulse_cfg_start();
    @(negedge clk_8m);
    cfg_start = 1'b1;
    @(negedge clk_8m);
    cfg_start = 1'b0;
  endtask

  task automatic wait_not_busy(input int budget, output bit ok, output int cycles);
    cycles = 0;
    while (cfg_busy && cycles < budget) begin
      @(negedge clk_8m);
      cycles++;
    end
    ok = !cfg_busy;
  endtask

  task automatic wait_man_ack(input int budget, output bit ok);
    int n = 0;
    while (!man_ack && n < budget) begin
      @(negedge clk_8m);
      n++;
    end
    ok = man_ack;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [50:0] obs;
    rst_n = 1'b0;
    repeat (3) @(negedge clk_8m);
    obs = {drv_start, drv_wr_rd, drv_dev, drv_reg, drv_data, man_ack, man_err,
           man_rd_data, cfg_busy, cfg_done, cfg_fail, fail_index};
    checks++;
    if (obs !== '0) begin failures++; $display("FAIL reset_outputs got=%h required=0", obs); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk_8m);
    checks++;
    if (state_dbg !== ST_IDLE || drv_start !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle state=%0d start=%b required state=0 start=0", state_dbg, drv_start);
    end
  endtask

  task automatic test_table_ok();
    bit ok; int cyc;
    for (int i = 0; i < 3; i++) push_ok(i);
    pulse_cfg_start();
    checks++;
    if (cfg_busy !== 1'b1) begin failures++; $display("FAIL table_busy got=%b required=1", cfg_busy); end
    wait_not_busy(2000, ok, cyc);
    checks++;
    if (!ok) begin failures++; $display("FAIL table_ok_timeout cfg_busy still 1 after %0d cycles", cyc); end
    @(negedge clk_8m);
    checks++;
    if ({cfg_done, cfg_fail} !== 2'b10) begin
      failures++; $display("FAIL table_ok_status done/fail=%b required=10", {cfg_done, cfg_fail});
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL table_ok_left pending=%0d required=0", exp_q.size());
    end
  endtask

  task automatic test_retry_fail();
    bit ok; int cyc;
    err_en = 1'b1;
    err_reg = tbl_reg[1];
    push_ok(0);
    for (int a = 0; a <= MAX_RETRY; a++) push_wr(1);
    pulse_cfg_start();
    wait_not_busy(3000, ok, cyc);
    checks++;
    if (!ok) begin failures++; $display("FAIL retry_timeout cfg_busy still 1 after %0d cycles", cyc); end
    repeat (30) @(negedge clk_8m);  // room for any stray attempt on entry 2
    checks++;
    if ({cfg_done, cfg_fail} !== 2'b01) begin
      failures++; $display("FAIL retry_status done/fail=%b required=01", {cfg_done, cfg_fail});
    end
    checks++;
    if (fail_index !== 4'd1) begin failures++; $display("FAIL retry_fail_index got=%0d required=1", fail_index); end
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL retry_left pending=%0d required=0", exp_q.size()); end
    err_en = 1'b0;
  endtask

  task automatic test_priority_manual();
    bit ok;
    for (int i = 0; i < 3; i++) push_ok(i);
    exp_q.push_back({1'b1, 8'h60, 16'h1234, 8'h00});
    @(negedge clk_8m);
    man_wr_rd = 1'b1; man_dev = 8'h60; man_reg = 16'h1234; man_data = 8'h00;
    cfg_start = 1'b1;
    man_req = 1'b1;
    @(negedge clk_8m);
    cfg_start = 1'b0;
    checks++;
    if (cfg_busy !== 1'b1) begin failures++; $display("FAIL prio_table_first cfg_busy=%b required=1", cfg_busy); end
    wait_man_ack(3000, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL prio_ack_timeout man_ack=0 required=1"); end
    checks++;
    if ({cfg_done, cfg_fail} !== 2'b10) begin
      failures++; $display("FAIL prio_done_before_ack done/fail=%b required=10", {cfg_done, cfg_fail});
    end
    checks++;
    if (man_rd_data !== 8'hA5 || man_err !== 1'b0) begin
      failures++; $display("FAIL prio_read data=%h err=%b required data=a5 err=0", man_rd_data, man_err);
    end
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL prio_left pending=%0d required=0", exp_q.size()); end
    man_req = 1'b0;
    @(negedge clk_8m);
    checks++;
    if (man_ack !== 1'b0) begin failures++; $display("FAIL prio_ack_pulse man_ack=%b required=0", man_ack); end
  endtask

  task automatic test_manual_write();
    bit ok;
    // Write with an injected error, then a clean one: man_err must follow each.
    for (int t = 0; t < 2; t++) begin
      err_en = (t == 0);
      err_reg = 16'h0042;
      exp_q.push_back({1'b0, 8'h61, 16'h0042, 8'h99});
      @(negedge clk_8m);
      man_wr_rd = 1'b0; man_dev = 8'h61; man_reg = 16'h0042; man_data = 8'h99;
      man_req = 1'b1;
      wait_man_ack(500, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL man_wr_ack_timeout t=%0d", t); end
      checks++;
      if (man_err !== (t == 0)) begin
        failures++; $display("FAIL man_wr_err t=%0d got=%b required=%b", t, man_err, (t == 0));
      end
      man_req = 1'b0;
    end
    err_en = 1'b0;
    @(negedge clk_8m);
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL man_wr_left pending=%0d required=0", exp_q.size()); end
  endtask

  task automatic test_timeout();
    bit ok; int cyc;
    resp_never = 1'b1;
    for (int a = 0; a <= MAX_RETRY; a++) push_wr(0);
    pulse_cfg_start();
    wait_not_busy(4 * (TMO + 20) + 100, ok, cyc);
    checks++;
    if (!ok) begin failures++; $display("FAIL tmo_no_end cfg_busy still 1 after %0d cycles", cyc); end
    checks++;
    if (cyc < 4 * TMO) begin failures++; $display("FAIL tmo_too_early cycles=%0d required>=%0d", cyc, 4 * TMO); end
    checks++;
    if ({cfg_done, cfg_fail, fail_index} !== {2'b01, 4'd0}) begin
      failures++; $display("FAIL tmo_status done/fail=%b idx=%0d required 01 idx 0", {cfg_done, cfg_fail}, fail_index);
    end
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL tmo_left pending=%0d required=0", exp_q.size()); end
    resp_never = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit ok; int cyc; int n;
    logic [50:0] obs;
    for (int i = 0; i < 3; i++) push_ok(i);
    pulse_cfg_start();
    n = 0;
    while (state_dbg !== ST_WAIT && n < 200) begin
      @(negedge clk_8m);
      n++;
    end
    checks++;
    if (state_dbg !== ST_WAIT) begin failures++; $display("FAIL rstmid_no_wait state=%0d required=%0d", state_dbg, ST_WAIT); end
    rst_n = 1'b0;
    #1;
    obs = {drv_start, drv_wr_rd, drv_dev, drv_reg, drv_data, man_ack, man_err,
           man_rd_data, cfg_busy, cfg_done, cfg_fail, fail_index};
    checks++;
    if (obs !== '0 || state_dbg !== ST_IDLE) begin
      failures++; $display("FAIL rstmid_outputs got=%h state=%0d required=0 state=0", obs, state_dbg);
    end
    exp_q.delete();
    repeat (3) @(negedge clk_8m);
    rst_n = 1'b1;
    repeat (2) @(negedge clk_8m);
    for (int i = 0; i < 3; i++) push_ok(i);
    pulse_cfg_start();
    wait_not_busy(2000, ok, cyc);
    @(negedge clk_8m);
    checks++;
    if (!ok || {cfg_done, cfg_fail} !== 2'b10) begin
      failures++; $display("FAIL rstmid_rerun ok=%b done/fail=%b required ok=1 10", ok, {cfg_done, cfg_fail});
    end
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL rstmid_left pending=%0d required=0", exp_q.size()); end
  endtask

`ifdef IIC_CFG_READBACK_EN
  task automatic test_readback();
    bit ok; int cyc;
    rd_echo = 1'b0;
    model_rd_data = 8'h00;
    for (int a = 0; a <= MAX_RETRY; a++) begin push_wr(0); push_rd(0); end
    pulse_cfg_start();
    wait_not_busy(3000, ok, cyc);
    @(negedge clk_8m);
    checks++;
    if (!ok || {cfg_done, cfg_fail, fail_index} !== {2'b01, 4'd0}) begin
      failures++; $display("FAIL rb_mismatch ok=%b done/fail=%b idx=%0d required 01 idx 0", ok, {cfg_done, cfg_fail}, fail_index);
    end
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL rb_mismatch_left pending=%0d required=0", exp_q.size()); end
    rd_echo = 1'b1;
    model_rd_data = 8'hA5;
    for (int i = 0; i < 3; i++) push_ok(i);
    pulse_cfg_start();
    wait_not_busy(3000, ok, cyc);
    @(negedge clk_8m);
    checks++;
    if (!ok || {cfg_done, cfg_fail} !== 2'b10) begin
      failures++; $display("FAIL rb_match ok=%b done/fail=%b required ok=1 10", ok, {cfg_done, cfg_fail});
    end
  endtask
`endif

  // ---------------- main sequence and report ----------------
  initial begin
    test_reset();
    test_table_ok();
    test_retry_fail();
    test_priority_manual();
    test_manual_write();
    test_timeout();
    test_reset_mid();
`ifdef IIC_CFG_READBACK_EN
    test_readback();
`endif
    repeat (5) @(negedge clk_8m);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/iic_cfg_sequencer.md
# iic_cfg_sequencer

Sequencer and arbiter in front of `iic_drive`. After power-up it walks a register-initialisation table and issues one I2C transaction per entry, with retry on error. Once idle, it grants single manual transactions from a debug requester (VIO). Runs on `clk_8m`; `iic_drive` samples the request on its divided `clk_i`, so every request uses a level handshake held until `drv_busy` rises.

## Interface
Parameters:
- `TABLE_DEPTH`, 16: maximum table entries; index width is `$clog2(TABLE_DEPTH)`.
- `MAX_RETRY`, 3: retries per entry after the first attempt.
- `TIMEOUT_CYC`, 65535: `clk_8m` cycles allowed in each of REQ and WAIT.

Ports (name, direction, width, meaning):
- `clk_8m`, in, 1: clock.
- `rst_n`, in, 1: reset. Asynchronous, active-low. Clock is `clk_8m`.
- `cfg_start`, in, 1: one-cycle pulse that starts a table run.
- `man_req`, in, 1: manual request level; held until `man_ack`.
- `man_wr_rd`, in, 1: manual direction. 0 = write, 1 = read.
- `man_dev`, in, 8: manual device address.
- `man_reg`, in, 16: manual register address.
- `man_data`, in, 8: manual write data.
- `man_ack`, out, 1: one-cycle pulse when the manual transaction completes.
- `man_rd_data`, out, 8: manual read result.
- `man_err`, out, 1: error status of the last manual transaction.
- `drv_start`, out, 1: request to `iic_drive`.
- `drv_wr_rd`, out, 1: direction to `iic_drive`.
- `drv_dev`, out, 8: device address to `iic_drive`.
- `drv_reg`, out, 16: register address to `iic_drive`.
- `drv_data`, out, 8: write data to `iic_drive`.
- `drv_busy`, in, 1: busy flag from `iic_drive`.
- `drv_err`, in, 1: error flag from `iic_drive`.
- `drv_rd_data`, in, 8: read data from `iic_drive`.
- `cfg_busy`, out, 1: table run in progress.
- `cfg_done`, out, 1: sticky; table run completed.
- `cfg_fail`, out, 1: sticky; table run aborted.
- `fail_index`, out, idx width: table index of the failing entry.

## Operation
- Reset values: all outputs 0. FSM in IDLE. Index and retry counters 0.
- `drv_busy` and `drv_err` are registered once on entry; all decisions use the registered copies.
- States:
  - IDLE → LOAD on `cfg_start`. A table run has priority over `man_req` in the same cycle. `man_req` stays pending and is served after the run.
  - IDLE → MLOAD on `man_req` when no `cfg_start` is present.
  - LOAD: fetch entry `idx` from the ROM.
    - If `dev == 8'hFF` or `idx == TABLE_DEPTH`, go to DONE.
    - Otherwise drive the `drv_*` fields and go to REQ.
  - REQ: `drv_start` = 1 until registered busy is seen = 1, then go to WAIT.
  - WAIT: hold until registered busy = 0, then go to CHECK.
  - CHECK, error case (`drv_err`, or timeout in REQ/WAIT):
    - If `retry < MAX_RETRY`: increment `retry` and go to REQ.
    - Otherwise set `cfg_fail` and `fail_index = idx`, and go to IDLE.
  - CHECK, no error: go to NEXT.
  - NEXT: `idx++`, `retry = 0`, go to LOAD.
  - DONE: set `cfg_done`, go to IDLE.
  - MLOAD / MREQ / MWAIT / MCHK: same handshake as REQ/WAIT/CHECK, with no retry. MCHK pulses `man_ack` and updates `man_err` and `man_rd_data`.
- `cfg_busy` = 1 in every table state (LOAD through DONE).
- `cfg_start` while `cfg_busy` is ignored. A new `cfg_start` clears `cfg_done` and `cfg_fail`.
- `drv_*` fields are stable from REQ entry until WAIT exit.
- Reset mid-transaction: `drv_start` drops immediately (asynchronous). `iic_drive` recovers on its own reset.

## Timing
- `drv_start` rises 1 cycle after LOAD and falls 1 cycle after registered busy = 1.
- Typical request hold: about 22 `clk_8m` cycles, i.e. 2 edges of the divide-by-20 `clk_i`.
- `man_ack` is asserted 1 cycle after registered busy falls.
- Timeout counter: reset on entry to REQ and on entry to WAIT. Expiry occurs when it reaches `TIMEOUT_CYC`.

## Configuration
- `IIC_CFG_READBACK_EN` defined: after each successful table write, issue a read of the same `dev`/`reg`.
  - If the read data does not equal the table data, treat it as an error and apply the normal retry rules.
  - `fail_index` reports the entry index.
- Undefined: table writes only, with no readback states.
- Manual path is identical in both cases.

## Structure
- Package `iic_cfg_pkg`:
  - state enum
  - entry struct `{dev[7:0], reg[15:0], data[7:0]}`
  - `END_MARK = 8'hFF`
- Sub-module `iic_cfg_rom`: combinational, index → entry, holds the table contents.

## Test plan
- Table of 3 entries then `END_MARK`, driver model without errors → 3 `drv_start` handshakes in order; `cfg_done` = 1; `cfg_fail` = 0.
- Entry 1 with `drv_err` on every attempt, `MAX_RETRY` = 3 → 4 attempts on entry 1; `cfg_fail` = 1; `fail_index` = 1; no attempt on entry 2.
- `cfg_start` and `man_req` in the same cycle → table runs first; `man_ack` follows `cfg_done`; manual read returns model data `8'hA5`.
- Driver model that never raises busy → timeout after 65535 cycles on each attempt; `cfg_fail` = 1 after 4 timeouts.
- `rst_n` low during WAIT → all outputs 0 the same cycle; a new `cfg_start` restarts from `idx` 0.
- With `IIC_CFG_READBACK_EN`: readback returns `8'h00` against written `8'h3C` → retries, then `cfg_fail`; with a matching model → `cfg_done`.
